// File: rtl/if_id_stage_if.sv
// Exception payload type and the fetch/decode handshake bundle for if_id_stage.
// The stage is the slave; the fetch/decode side (or a bench) is the master.
package Exception_Pkg;
  typedef struct packed {
    logic       raise;
    logic [3:0] code;
  } exception_t;
endpackage

interface if_id_stage_if;
  import Exception_Pkg::*;

  logic        if_valid;
  logic        if_ready;
  logic [31:0] instruction_addr_if;
  logic [31:0] instruction_if;
  exception_t  exception_if;
  logic        flush;

  logic        id_valid;
  logic        id_ready;
  logic [31:0] instruction_addr_id;
  logic [31:0] instruction_id;
  exception_t  exception_id;

  modport master (
    output if_valid, instruction_addr_if, instruction_if, exception_if, flush, id_ready,
    input  if_ready, id_valid, instruction_addr_id, instruction_id, exception_id
  );

  modport slave (
    input  if_valid, instruction_addr_if, instruction_if, exception_if, flush, id_ready,
    output if_ready, id_valid, instruction_addr_id, instruction_id, exception_id
  );
endinterface

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with valid/ready handshake and flush.
// Define IF_ID_SKID_BUFFER_EN for a two-entry skid buffer with registered if_ready.
module if_id_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             rst_n,
  if_id_stage_if.slave     bus
);
  import Exception_Pkg::*;

`ifdef IF_ID_SKID_BUFFER_EN
  typedef enum logic [1:0] {EMPTY, FULL, SKID} state_e;
`else
  typedef enum logic [1:0] {EMPTY, FULL} state_e;
`endif

  state_e      state_q;
  logic        id_valid_q;
  logic [31:0] main_addr_q;
  logic [31:0] main_instr_q;
  exception_t  main_exc_q;

  logic accept;
  logic retire;

  assign accept = bus.if_valid && bus.if_ready;
  assign retire = id_valid_q && bus.id_ready;

`ifdef IF_ID_SKID_BUFFER_EN
  logic        if_ready_q;
  logic [31:0] skid_addr_q;
  logic [31:0] skid_instr_q;
  exception_t  skid_exc_q;

  // Ready depends only on state, so no path from id_ready back to fetch.
  assign bus.if_ready = if_ready_q;

  // NOTE: skid data needs no reset; it is only ever read after being written.
  always_ff @(posedge clk) begin
    if (accept && state_q == FULL) begin
      skid_addr_q  <= bus.instruction_addr_if;
      skid_instr_q <= bus.instruction_if;
      skid_exc_q   <= bus.exception_if;
    end
  end
`else
  assign bus.if_ready = bus.id_ready || !id_valid_q;
`endif

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      id_valid_q   <= 1'b0;
      main_addr_q  <= 32'h0;
      main_instr_q <= NOP_INSTR;
      main_exc_q   <= '0;
`ifdef IF_ID_SKID_BUFFER_EN
      if_ready_q   <= 1'b1;
`endif
    end else if (bus.flush) begin
      state_q    <= EMPTY;
      id_valid_q <= 1'b0;
`ifdef IF_ID_SKID_BUFFER_EN
      if_ready_q <= 1'b1;
`endif
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_q      <= FULL;
            id_valid_q   <= 1'b1;
            main_addr_q  <= bus.instruction_addr_if;
            main_instr_q <= bus.instruction_if;
            main_exc_q   <= bus.exception_if;
          end
        end
        FULL: begin
          if (accept && retire) begin
            main_addr_q  <= bus.instruction_addr_if;
            main_instr_q <= bus.instruction_if;
            main_exc_q   <= bus.exception_if;
          end else if (retire) begin
            state_q    <= EMPTY;
            id_valid_q <= 1'b0;
`ifdef IF_ID_SKID_BUFFER_EN
          end else if (accept) begin
            state_q    <= SKID;
            if_ready_q <= 1'b0;
`endif
          end
        end
`ifdef IF_ID_SKID_BUFFER_EN
        SKID: begin
          if (retire) begin
            state_q      <= FULL;
            if_ready_q   <= 1'b1;
            main_addr_q  <= skid_addr_q;
            main_instr_q <= skid_instr_q;
            main_exc_q   <= skid_exc_q;
          end
        end
`endif
        default: begin
          state_q    <= EMPTY;
          id_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // The payload registers keep their last contents while empty; only the visible fields are masked.
  assign bus.id_valid            = id_valid_q;
  assign bus.instruction_addr_id = main_addr_q;
  assign bus.instruction_id      = id_valid_q ? main_instr_q : NOP_INSTR;
  assign bus.exception_id        = '{raise: main_exc_q.raise && id_valid_q, code: main_exc_q.code};

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed scenarios then randomized traffic,
// compared against a queue-based model of the held beats.
module tb_if_id_stage;
  import Exception_Pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IF_ID_SKID_BUFFER_EN
  localparam bit SKID_EN = 1'b1;
`else
  localparam bit SKID_EN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
    exception_t  exc;
  } beat_t;

  logic clk;
  logic rst_n;
  if_id_stage_if bus ();

  if_id_stage #(.NOP_INSTR(NOP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_vec = 0;
  int    n_err = 0;
  beat_t held[$];
  beat_t last;
  bit    known = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Capacity is two beats with the skid entry, one without; without it the
  // stage may also take a beat when decode drains the held one in the same cycle.
  function automatic bit model_ready(input bit rdy);
    if (SKID_EN) return held.size() < 2;
    return rdy || held.size() == 0;
  endfunction

  task automatic model_step(input bit rst, input bit acc, input beat_t b, input bit fl, input bit rdy);
    if (!rst) begin
      held.delete();
      last.addr  = 32'h0;
      last.instr = NOP;
      last.exc   = '0;
      known      = 1'b1;
    end else begin
      if (held.size() > 0 && rdy) void'(held.pop_front());
      if (acc) held.push_back(b);
      if (fl) held.delete();
      if (held.size() > 0) last = held[0];
    end
  endtask

  task automatic check_outputs();
    exception_t exp_exc;
    if (!known) return;
    check("id_valid", bus.id_valid, held.size() > 0);
    if (held.size() > 0) begin
      check("instr_id", bus.instruction_id, held[0].instr);
      check("addr_id", bus.instruction_addr_id, held[0].addr);
      check("exc_id", bus.exception_id, held[0].exc);
    end else begin
      exp_exc = '{raise: 1'b0, code: last.exc.code};
      check("instr_id_nop", bus.instruction_id, NOP);
      check("addr_id_hold", bus.instruction_addr_id, last.addr);
      check("exc_id_mask", bus.exception_id, exp_exc);
    end
  endtask

  task automatic cycle(input bit rst, input bit valid, input logic [31:0] addr,
                       input logic [31:0] instr, input exception_t exc,
                       input bit fl, input bit rdy);
    bit    exp_rdy;
    beat_t b;
    rst_n                   = rst;
    bus.if_valid            = valid;
    bus.instruction_addr_if = addr;
    bus.instruction_if      = instr;
    bus.exception_if        = exc;
    bus.flush               = fl;
    bus.id_ready            = rdy;
    #1;
    exp_rdy = model_ready(rdy);
    if (known) check("if_ready", bus.if_ready, exp_rdy);
    b.addr  = addr;
    b.instr = instr;
    b.exc   = exc;
    @(posedge clk);
    model_step(rst, valid && exp_rdy, b, fl, rdy);
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    exception_t no_exc;
    exception_t exc1;
    exception_t rexc;
    no_exc = '0;
    exc1   = '{raise: 1'b1, code: 4'd1};

    rst_n           = 1'b0;
    bus.if_valid    = 1'b0;
    bus.flush       = 1'b0;
    bus.id_ready    = 1'b0;
    bus.instruction_addr_if = '0;
    bus.instruction_if      = '0;
    bus.exception_if        = '0;
    @(negedge clk);

    // Reset with a beat on offer: it must be dropped.
    cycle(0, 1, 32'hDEAD_0000, 32'h1111_1111, exc1, 0, 0);
    cycle(0, 1, 32'hDEAD_0004, 32'h2222_2222, exc1, 1, 1);
    check("rst_id_valid", bus.id_valid, 1'b0);
    check("rst_if_ready", bus.if_ready, 1'b1);
    check("rst_addr", bus.instruction_addr_id, 32'h0);

    // First beat appears one cycle after acceptance.
    cycle(1, 1, 32'h100, 32'h0050_0093, no_exc, 0, 0);
    check("first_addr", bus.instruction_addr_id, 32'h100);
    check("first_instr", bus.instruction_id, 32'h0050_0093);
    // Stall decode while B is offered, then drain.
    cycle(1, 1, 32'h104, 32'h0060_0113, no_exc, 0, 0);
    check("stall_head", bus.instruction_addr_id, 32'h100);
    if (SKID_EN) check("skid_ready", bus.if_ready, 1'b0);
    cycle(1, 0, 32'h0, 32'h0, no_exc, 0, 1);
    cycle(1, 0, 32'h0, 32'h0, no_exc, 0, 1);
    cycle(1, 0, 32'h0, 32'h0, no_exc, 0, 1);

    // Fill, then flush: neither beat may surface.
    cycle(1, 1, 32'h100, 32'h0050_0093, no_exc, 0, 0);
    cycle(1, 1, 32'h104, 32'h0060_0113, no_exc, 0, 0);
    cycle(1, 1, 32'h108, 32'h0070_0193, no_exc, 1, 1);
    check("flush_nop", bus.instruction_id, 32'h0000_0013);
    check("flush_ready", bus.if_ready, 1'b1);
    cycle(1, 0, 32'h0, 32'h0, no_exc, 0, 1);

    // Exception travels with its PC and is masked once retired.
    cycle(1, 1, 32'h200, 32'h0000_0000, exc1, 0, 0);
    check("exc_raise", bus.exception_id, exc1);
    check("exc_addr", bus.instruction_addr_id, 32'h200);
    cycle(1, 0, 32'h0, 32'h0, no_exc, 0, 1);
    check("exc_after_retire", bus.exception_id.raise, 1'b0);

    // Streaming: one beat per cycle in order.
    for (int i = 0; i < 8; i++) begin
      cycle(1, 1, 32'(i * 4), 32'h0000_1000 + 32'(i), no_exc, 0, 1);
      check("stream_pc", bus.instruction_addr_id, 32'(i * 4));
    end
    cycle(1, 0, 32'h0, 32'h0, no_exc, 0, 1);

    // Reset while holding a beat and being offered another.
    cycle(1, 1, 32'h300, 32'hABCD_0001, no_exc, 0, 0);
    cycle(0, 1, 32'h304, 32'hABCD_0002, no_exc, 0, 0);
    check("rst_full_valid", bus.id_valid, 1'b0);
    cycle(1, 0, 32'h0, 32'h0, no_exc, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      rexc.raise = 1'($urandom_range(0, 1));
      rexc.code  = 4'($urandom);
      cycle(($urandom_range(0, 59) != 0),
            ($urandom_range(0, 3) != 0),
            $urandom, $urandom, rexc,
            ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 2) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 SHALL have parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0); instruction presented downstream when no valid entry.
REQ-002 SHALL have clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have if_valid  input  1  fetch stage offers a beat.
REQ-005 SHALL have if_ready  output  1  stage accepts the offered beat this cycle.
REQ-006 SHALL have instruction_addr_if  input  32  PC of offered instruction.
REQ-007 SHALL have instruction_if  input  32  offered instruction word.
REQ-008 SHALL have exception_if  input  exception_t (Exception_Pkg)  fetch-side exception {raise, code}.
REQ-009 SHALL have flush  input  1  discard all held and offered beats (branch/trap redirect).
REQ-010 SHALL have id_valid  output  1  decode-side beat valid.
REQ-011 SHALL have id_ready  input  1  decode stage consumes the beat this cycle.
REQ-012 SHALL have instruction_addr_id  output  32  PC of held beat.
REQ-013 SHALL have instruction_id  output  32  held instruction, NOP_INSTR when id_valid=0.
REQ-014 SHALL have exception_id  output  exception_t  held exception; raise forced 0 when id_valid=0.

Function
REQ-015 SHALL accept a beat on cycle where if_valid && if_ready; SHALL retire a beat where id_valid && id_ready.
REQ-016 SHALL have states EMPTY (no entry), FULL (main entry), SKID (main + skid entry); id_valid=1 in FULL/SKID.
REQ-017 SHALL drive if_ready=1 in EMPTY/FULL, 0 in SKID; if_ready SHALL be a registered function of state (no combinational path from id_ready).
REQ-018 EMPTY: accept -> FULL, main loads beat; latency input-to-output exactly 1 cycle.
REQ-019 FULL: accept+retire -> FULL, main loads new beat; retire only -> EMPTY; accept only -> SKID, beat stored in skid; neither -> FULL, hold.
REQ-020 SKID: retire -> FULL, main loads skid contents; no retire -> SKID, hold; no accept possible.
REQ-021 SHALL preserve strict program order; no beat duplicated or dropped except by flush.
REQ-022 flush=1 SHALL force next state EMPTY regardless of state, if_valid, id_ready; a beat offered in the same cycle is consumed (if_ready per state) and discarded.
REQ-023 SHALL pass exception_if through with its beat unchanged; raise+code travel with the same PC/instruction.
REQ-024 Payload registers in EMPTY SHALL hold last values for instruction_addr_id; instruction_id and exception_id.raise masked per REQ-013/014.

Reset
REQ-025 rst_n=0 at a rising edge SHALL force EMPTY; id_valid=0, instruction_id=NOP_INSTR, instruction_addr_id=32'h0, exception_id={0,0}, if_ready=1 in the following cycle.
REQ-026 Reset SHALL dominate flush and any handshake in the same cycle; a beat offered during reset is discarded.

Configuration
REQ-027 Macro IF_ID_SKID_BUFFER_EN defined: SHALL implement REQ-016..020 as written.
REQ-028 Macro undefined: SHALL omit skid entry and SKID state; if_ready = id_ready || !id_valid (combinational); FULL with accept-only impossible; all other requirements unchanged.

Verification
REQ-029 Reset release, if_valid=1, addr=32'h100, instr=32'h00500093 -> next cycle id_valid=1, instruction_addr_id=32'h100, instruction_id=32'h00500093.
REQ-030 id_ready=0 held, beats A(0x100), B(0x104) back-to-back -> SKID, if_ready=0, output A; id_ready=1 one cycle -> output B, if_ready=1 (macro defined).
REQ-031 State SKID, flush=1 -> next cycle id_valid=0, instruction_id=32'h00000013, if_ready=1; neither A nor B ever retired.
REQ-032 exception_if={1,code 1} at addr 32'h200 -> exception_id={1,1} with instruction_addr_id=32'h200; on retire-only next cycle raise=0.
REQ-033 Continuous if_valid=1, id_ready=1, 8 sequential PCs from 32'h0 step 4 -> 8 retired in order, one per cycle, no bubbles after first.
REQ-034 rst_n=0 while FULL with if_valid=1 -> id_valid=0 next cycle, offered beat never appears.
